// File: rtl/shift_register_u.sv
// Universal WIDTH-bit register: load/clear plus multi-cycle shift/rotate, one bit-step per clock.
// Optional abort of an in-flight shift when SHIFT_REGISTER_U_ABORT_EN is defined.
module shift_register_u #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH):0]     shamt,
  input  logic                       serial_in,
  output logic [WIDTH-1:0]           data_reg,
  output logic                       serial_out,
`ifdef SHIFT_REGISTER_U_ABORT_EN
  input  logic                       abort,
  output logic                       aborted,
`endif
  output logic                       done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpClear = 3'b010;
  localparam logic [2:0] OpShl   = 3'b011;
  localparam logic [2:0] OpShr   = 3'b100;
  localparam logic [2:0] OpRol   = 3'b101;
  localparam logic [2:0] OpRor   = 3'b110;
  localparam logic [2:0] OpAsr   = 3'b111;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sout_q, sout_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              abort_w;

  logic [2:0]        step_op;
  logic [WIDTH-1:0]  step_data;
  logic              step_out;

`ifdef SHIFT_REGISTER_U_ABORT_EN
  assign abort_w = abort;
  assign aborted = aborted_q;
`else
  assign abort_w = 1'b0;
`endif

  // The step uses the live op on the accept edge and the latched op afterwards.
  assign step_op = (state_q == StIdle) ? op : op_q;

  always_comb begin
    step_data = data_q;
    step_out  = sout_q;
    case (step_op)
      OpShl: begin
        step_data = {data_q[WIDTH-2:0], serial_in};
        step_out  = data_q[WIDTH-1];
      end
      OpShr: begin
        step_data = {serial_in, data_q[WIDTH-1:1]};
        step_out  = data_q[0];
      end
      OpRol: begin
        step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        step_out  = data_q[WIDTH-1];
      end
      OpRor: begin
        step_data = {data_q[0], data_q[WIDTH-1:1]};
        step_out  = data_q[0];
      end
      OpAsr: begin
        step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        step_out  = data_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sout_d    = sout_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          case (op)
            OpNop:   done_d = 1'b1;
            OpLoad: begin
              data_d = data_in;
              done_d = 1'b1;
            end
            OpClear: begin
              data_d = '0;
              done_d = 1'b1;
            end
            default: begin
              op_d = op;
              if (shamt == '0) begin
                done_d = 1'b1;
              end else begin
                data_d = step_data;
                sout_d = step_out;
                cnt_d  = shamt - CntW'(1);
                if (shamt == CntW'(1)) begin
                  done_d = 1'b1;
                end else begin
                  state_d = StShift;
                end
              end
            end
          endcase
        end
      end
      StShift: begin
        if (abort_w) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else begin
          data_d = step_data;
          sout_d = step_out;
          cnt_d  = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      data_q    <= RESET_VALUE;
      cnt_q     <= '0;
      op_q      <= OpNop;
      sout_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sout_q    <= sout_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign op_ready   = (state_q == StIdle);
  assign data_reg   = data_q;
  assign serial_out = sout_q;
  assign done       = done_q;

`ifndef SHIFT_REGISTER_U_ABORT_EN
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_shift_register_u.sv
// Directed-vector bench for shift_register_u (WIDTH=8, RESET_VALUE=0).
module tb_shift_register_u;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op;
  logic [7:0] data_in;
  logic [3:0] shamt;
  logic       serial_in;
  logic [7:0] data_reg;
  logic       serial_out;
  logic       done;
  logic       abort;
  logic       aborted;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  shift_register_u #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .data_in    (data_in),
    .shamt      (shamt),
    .serial_in  (serial_in),
    .data_reg   (data_reg),
    .serial_out (serial_out),
`ifdef SHIFT_REGISTER_U_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .done       (done)
  );

`ifndef SHIFT_REGISTER_U_ABORT_EN
  assign aborted = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-cycle command: accepted at the next edge, checked at the following negedge.
  task automatic simple_cmd(input string tag, input logic [2:0] o, input logic [7:0] d,
                            input logic [7:0] exp_data);
    @(negedge clk);
    op_valid = 1'b1; op = o; data_in = d;
    @(negedge clk);
    op_valid = 1'b0;
    chk({tag, "_data"}, 32'(data_reg), 32'(exp_data));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ready"}, 32'(op_ready), 32'd1);
  endtask

  // Shift command: counts busy cycles (bounded), then checks result and done.
  task automatic shift_cmd(input string tag, input logic [2:0] o, input logic [3:0] n,
                           input logic sin, input int exp_busy, input logic [7:0] exp_data,
                           input logic exp_sout);
    int busy;
    @(negedge clk);
    op_valid = 1'b1; op = o; shamt = n; serial_in = sin; data_in = 8'h5A;
    @(negedge clk);
    op_valid = 1'b0;
    busy = 0;
    while (!op_ready && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_data"}, 32'(data_reg), 32'(exp_data));
    chk({tag, "_sout"}, 32'(serial_out), 32'(exp_sout));
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op = 3'b000; data_in = '0; shamt = '0;
    serial_in = 1'b0; abort = 1'b0;
    #3;
    chk("rst_data", 32'(data_reg), 32'h00);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sout", 32'(serial_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // LOAD then back-to-back NOP
    simple_cmd("load_a5", 3'b001, 8'hA5, 8'hA5);
    chk("load_a5_sout", 32'(serial_out), 32'd0);
    op_valid = 1'b1; op = 3'b000; data_in = 8'h11;
    @(negedge clk);
    op_valid = 1'b0;
    chk("nop_data", 32'(data_reg), 32'hA5);
    chk("nop_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("nop_done_drop", 32'(done), 32'd0);

    // SHL 3 with serial_in=1; op_valid held during busy must be ignored
    op_valid = 1'b1; op = 3'b011; shamt = 4'd3; serial_in = 1'b1;
    @(negedge clk);
    op = 3'b001; data_in = 8'h00;
    chk("shl_s1_data", 32'(data_reg), 32'h4B);
    chk("shl_s1_ready", 32'(op_ready), 32'd0);
    chk("shl_s1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("shl_s2_data", 32'(data_reg), 32'h97);
    chk("shl_s2_ready", 32'(op_ready), 32'd0);
    chk("shl_s2_done", 32'(done), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    chk("shl_data", 32'(data_reg), 32'h2F);
    chk("shl_sout", 32'(serial_out), 32'd1);
    chk("shl_done", 32'(done), 32'd1);
    chk("shl_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    chk("shl_done_drop", 32'(done), 32'd0);
    chk("shl_hold", 32'(data_reg), 32'h2F);

    // ROR by more than WIDTH
    simple_cmd("load_81", 3'b001, 8'h81, 8'h81);
    shift_cmd("ror12", 3'b110, 4'd12, 1'b0, 11, 8'h18, 1'b0);

    // ASR sign fill, then SHR shamt=0 leaves everything alone
    simple_cmd("load_90", 3'b001, 8'h90, 8'h90);
    shift_cmd("asr2", 3'b111, 4'd2, 1'b0, 1, 8'hE4, 1'b0);
    shift_cmd("shr0", 3'b100, 4'd0, 1'b1, 0, 8'hE4, 1'b0);

    // ROL single step, CLEAR, SHR filling ones
    simple_cmd("load_81b", 3'b001, 8'h81, 8'h81);
    shift_cmd("rol1", 3'b101, 4'd1, 1'b0, 0, 8'h03, 1'b1);
    simple_cmd("clear", 3'b010, 8'hFF, 8'h00);
    shift_cmd("shr2_fill1", 3'b100, 4'd2, 1'b1, 1, 8'hC0, 1'b0);

    // Reset mid-operation discards the shift
    simple_cmd("load_ff", 3'b001, 8'hFF, 8'hFF);
    @(negedge clk);
    op_valid = 1'b1; op = 3'b100; shamt = 4'd5; serial_in = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    chk("shr5_s1", 32'(data_reg), 32'h7F);
    @(negedge clk);
    chk("shr5_s2", 32'(data_reg), 32'h3F);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_data", 32'(data_reg), 32'h00);
    chk("midrst_ready", 32'(op_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sout", 32'(serial_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_done", 32'(done), 32'd0);
      chk("postrst_data", 32'(data_reg), 32'h00);
    end

`ifdef SHIFT_REGISTER_U_ABORT_EN
    simple_cmd("ab_load_ff", 3'b001, 8'hFF, 8'hFF);
    @(negedge clk);
    op_valid = 1'b1; op = 3'b100; shamt = 4'd5; serial_in = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_data", 32'(data_reg), 32'h3F);
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    chk("abort_pulse_drop", 32'(aborted), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_hold", 32'(data_reg), 32'h3F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/shift_register_u.md
Name: shift_register_u

Overview:
Parametrised universal register with a multi-cycle shift/rotate engine; successor to the single-bit set/hold register.
- Holds a WIDTH-bit value.
- Supports parallel load, clear, and logical/arithmetic shifts and rotates by a programmable step count.
- Executes one bit-step per clock under a valid/ready command handshake.
- Serves as the accumulator/shifter element of the datapath.

Parameters:
WIDTH, 8, data width in bits (>=2)
RESET_VALUE, 0, value loaded into data_reg on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
op_valid  input  1  command present
op_ready  output  1  block can accept a command (high in IDLE)
op  input  3  000 NOP, 001 LOAD, 010 CLEAR, 011 SHL, 100 SHR, 101 ROL, 110 ROR, 111 ASR
data_in  input  WIDTH  LOAD value
shamt  input  $clog2(WIDTH)+1  number of single-bit steps for shift/rotate ops
serial_in  input  1  fill bit for SHL (enters bit0) and SHR (enters MSB); sampled every step
data_reg  output  WIDTH  register contents
serial_out  output  1  bit shifted/rotated out by the most recent step
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous, overrides everything):
  - data_reg=RESET_VALUE, serial_out=0, done=0, state=IDLE, op_ready=1.
  - Applies immediately, including mid-operation; any in-flight operation is discarded and no done is issued.
- States: IDLE, SHIFT. op_ready = (state==IDLE); purely a function of state.
- Accept = op_valid & op_ready at a rising edge. op_valid while not ready is ignored; the command is not queued.
- NOP / LOAD / CLEAR:
  - Complete at the accept edge: NOP leaves data_reg unchanged; LOAD sets data_reg=data_in; CLEAR sets data_reg=0.
  - serial_out unchanged; state stays IDLE; done=1 for the following cycle.
- Shift ops (SHL, SHR, ROL, ROR, ASR):
  - Op and shamt are latched at accept; data_in and op are ignored afterwards.
  - shamt=0: no change to data_reg or serial_out; done=1 next cycle; stay IDLE.
  - shamt>=1: the first step is performed at the accept edge, remaining count = shamt-1.
    - If the remaining count is 0, stay IDLE; otherwise go to SHIFT.
    - In SHIFT, one step per edge with the count decremented; after the final step return to IDLE.
    - Total steps = shamt; op_ready is low for shamt-1 cycles; done=1 in the cycle after the final step edge.
  - shamt up to WIDTH (and larger) is legal; rotates wrap naturally; SHL/SHR keep filling serial_in.
- Step definitions:
  - SHL: {d[W-2:0],serial_in}, out=d[W-1].
  - SHR: {serial_in,d[W-1:1]}, out=d[0].
  - ROL: {d[W-2:0],d[W-1]}, out=d[W-1].
  - ROR: {d[0],d[W-1:1]}, out=d[0].
  - ASR: {d[W-1],d[W-1:1]}, out=d[0].
- done is registered, high exactly one cycle per completed command. op_ready is high in the done cycle, so a back-to-back accept in that cycle is legal.
- data_reg changes only at accept or SHIFT edges; it holds otherwise.

Optional Feature:
SHIFT_REGISTER_U_ABORT_EN
- Defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 at an edge while in SHIFT: no step is performed; return to IDLE; data_reg keeps its partial result; aborted=1 for one cycle; done stays 0.
  - abort in IDLE is ignored; abort has priority over the step.
- Undefined: the ports are absent and operations always run to completion.

Test Plan:
- Reset: drive reset=0 mid-cycle with WIDTH=8 -> data_reg=0x00, op_ready=1, done=0 immediately, without waiting for a clock edge.
- LOAD 0xA5 then NOP -> data_reg=0xA5 after the first edge; done high one cycle after each command; serial_out=0.
- From 0xA5, SHL shamt=3, serial_in=1 -> op_ready low 2 cycles; data_reg=0x2F; serial_out=1; single done pulse; op_valid pulses during busy are ignored.
- LOAD 0x81, ROR shamt=12 -> 12 steps (op_ready low 11 cycles); data_reg=0x18; serial_out=0.
- LOAD 0x90, ASR shamt=2 -> data_reg=0xE4, serial_out=0. Then SHR shamt=0 -> data_reg stays 0xE4, done next cycle.
- LOAD 0xFF, SHR shamt=5, serial_in=0; assert reset after 2 steps (data_reg=0x3F) -> data_reg=0x00 at once, op_ready=1, no done pulse.
- With SHIFT_REGISTER_U_ABORT_EN defined: same SHR with abort at the 3rd edge -> data_reg=0x3F, aborted pulse, done stays 0.
